hbridge_pwm_ctrl: RTL and testbench
===================================

// Module: hbridge_pwm_ctrl
// PURPOSE
//  Four-switch H-bridge buck/boost/buck-boost PWM generator with a programmable resolution.
//  Adds per-leg dead-time insertion, period-boundary shadowing of duty/mode/dead-time,
//  soft-start ramping and a latched fault shutdown. Sits between the control loop
//  (duty/mode source) and the gate-driver pins.
// PARAMETERS
//  CNT_W      8   counter/duty width; period = 2**CNT_W sys_clk cycles
//  DT_W       4   dead-time counter width (max dead time 2**DT_W-1 cycles)
//  RAMP_STEP  16  soft-start duty increment per period (CNT_W bits, >0)
// PORTS
//  sys_clk       in   1      system clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  duty          in   CNT_W  requested duty, 0..2**CNT_W-1
//  mode          in   2      00 OFF, 01 BUCK, 10 BOOST, 11 BUCK_BOOST
//  dead_time     in   DT_W   dead time in sys_clk cycles
//  fault         in   1      fault request, synchronous to sys_clk, active high
//  fault_clr     in   1      fault-latch clear, active high
//  PWM_HIGH_1    out  1      leg-1 high-side gate
//  PWM_LOW_1     out  1      leg-1 low-side gate
//  PWM_HIGH_2    out  1      leg-2 high-side gate
//  PWM_LOW_2     out  1      leg-2 low-side gate
//  period_start  out  1      one-cycle pulse while cnt==0
//  fault_latched out  1      fault latch state
// BEHAVIOUR
//  Reset: cnt=0; shadows duty_sh=0, mode_sh=OFF, dt_sh=0; duty_eff=0; pwm_raw=0.
//    All four gate outputs, period_start and fault_latched reset to 0.
//  Counter: cnt increments every cycle and wraps from 2**CNT_W-1 to 0.
//  Boundary = cycle with cnt==MAX. At a boundary, load duty_sh<=duty, mode_sh<=mode and dt_sh<=dead_time.
//    Mid-period changes on the inputs have no effect.
//  Soft-start, evaluated at each boundary:
//    - Loaded mode is OFF: duty_eff<=0.
//    - mode_sh was OFF and the loaded mode is not OFF: duty_eff<=0.
//    - Otherwise: duty_eff<=min(duty_eff+RAMP_STEP, new duty_sh), with the sum saturating at CNT_W bits.
//    - A lower duty therefore takes effect at the next boundary with no ramp.
//  Raw PWM: pwm_raw(t+1) = (cnt(t) < duty_eff(t)).
//    duty_eff=0 gives always low; the maximum on-time is 2**CNT_W-1 of 2**CNT_W cycles.
//  Leg target, each leg one of {OFF, HI, LO}, from mode_sh and pwm_raw:
//    OFF:        leg1=OFF, leg2=OFF
//    BUCK:       leg1=pwm_raw?HI:LO, leg2=HI
//    BOOST:      leg1=HI, leg2=pwm_raw?LO:HI
//    BUCK_BOOST: pwm_raw ? (leg1=HI, leg2=LO) : (leg1=LO, leg2=HI)
//  Dead time, independent per leg, outputs registered:
//    - Target changes to HI or LO: leg outputs drive 0/0 for exactly dt_sh cycles, then assert the target.
//    - dt_sh=0: the target appears on the next clock, giving 2-cycle latency from cnt to the pin.
//    - Target changes again during dead time: the dead-time counter reloads and the new target applies.
//      Pulses shorter than dt_sh are swallowed.
//    - Target changes to OFF: outputs go 0/0 on the next clock with no delay.
//    - Invariant: HIGH_n and LOW_n are never both 1 in any cycle, including mode changes and fault.
//  Fault:
//    - fault=1: fault_latched=1 and all gates 0 on the next clock, overriding everything.
//    - While latched: mode_sh is forced OFF and duty_eff=0; the counter keeps running.
//    - fault_clr=1 with fault=0 clears the latch on the next clock.
//      The block then stays OFF until the next boundary, which loads mode and restarts soft-start.
//    - fault and fault_clr together: fault wins.
//    - fault_clr with no fault latched: no effect.
//  Reset mid-operation: asynchronous return to reset values; gates drop to 0 immediately.
// TESTING
//  1. Assert rst_n=0 mid-period in BUCK -> all gates 0 at once; fault_latched=0; cnt=0 after release.
//  2. CNT_W=8, mode=01, duty=64, dt=0, after ramp:
//     HIGH_1 high 64 of 256 cycles; LOW_1 high 192; HIGH_2=1, LOW_2=0.
//  3. BUCK, duty=128, dt=3:
//     HIGH_1 high 125 cycles; LOW_1 high 125 cycles; 3 cycles of 0/0 at each edge.
//  4. RAMP_STEP=16, mode 00->01, duty=64:
//     duty_eff per period 0,16,32,48,64,64; then duty->32 gives 32 at the next period.
//  5. BUCK_BOOST, fault=1 mid-period -> gates 0 next cycle, fault_latched=1.
//     fault_clr while fault=1 is ignored. After fault=0 and fault_clr: OFF until the boundary, then ramp from 0.
//  6. Mode 01->10 mid-period -> no change until cnt wraps.
//     Leg transitions insert dt_sh dead time; assertion that HIGH_n&LOW_n==0 holds throughout a random mode/duty/dt run.

Source files
------------

// File: rtl/hbridge_pwm_ctrl.sv
// hbridge_pwm_ctrl: four-switch H-bridge PWM with dead time, boundary shadowing, soft-start and fault latch
module hbridge_pwm_ctrl #(
    parameter int CNT_W     = 8,
    parameter int DT_W      = 4,
    parameter int RAMP_STEP = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] duty,
    input  logic [1:0]       mode,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             PWM_HIGH_1,
    output logic             PWM_LOW_1,
    output logic             PWM_HIGH_2,
    output logic             PWM_LOW_2,
    output logic             period_start,
    output logic             fault_latched
);
    localparam logic [1:0]       M_OFF   = 2'b00;
    localparam logic [1:0]       M_BUCK  = 2'b01;
    localparam logic [1:0]       M_BOOST = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {LEG_OFF, LEG_HI, LEG_LO} leg_t;

    logic [CNT_W-1:0] cnt, duty_eff, ramp_sat, ramp_next;
    logic [CNT_W:0]   ramp_sum;
    logic [1:0]       mode_sh;
    logic [DT_W-1:0]  dt_sh;
    logic             pwm_raw, boundary, trip;
    leg_t             tgt [2];
    leg_t             cur [2];
    logic [DT_W-1:0]  dt_cnt [2];
    logic [1:0]       hi, lo;

    assign boundary  = cnt == CNT_MAX;
    assign trip      = fault | fault_latched;
    assign ramp_sum  = {1'b0, duty_eff} + (CNT_W+1)'(RAMP_STEP);
    assign ramp_sat  = ramp_sum[CNT_W] ? CNT_MAX : ramp_sum[CNT_W-1:0];
    assign ramp_next = ramp_sat < duty ? ramp_sat : duty;

    assign tgt[0] = mode_sh == M_OFF ? LEG_OFF : (mode_sh == M_BOOST || pwm_raw) ? LEG_HI : LEG_LO;
    assign tgt[1] = mode_sh == M_OFF ? LEG_OFF : (mode_sh == M_BUCK || !pwm_raw) ? LEG_HI : LEG_LO;

    assign PWM_HIGH_1 = hi[0];
    assign PWM_LOW_1  = lo[0];
    assign PWM_HIGH_2 = hi[1];
    assign PWM_LOW_2  = lo[1];

    // Period counter, boundary shadow loads, soft-start ramp and fault latch
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            mode_sh       <= M_OFF;
            dt_sh         <= '0;
            duty_eff      <= '0;
            pwm_raw       <= 1'b0;
            period_start  <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            cnt           <= cnt + 1'b1;
            period_start  <= boundary;
            pwm_raw       <= cnt < duty_eff;
            fault_latched <= fault | (fault_latched & ~fault_clr);
            if (boundary)
                dt_sh <= dead_time;
            if (trip) begin
                mode_sh  <= M_OFF;
                duty_eff <= '0;
            end else if (boundary) begin
                mode_sh  <= mode;
                duty_eff <= (mode == M_OFF || mode_sh == M_OFF) ? '0 : ramp_next;
            end
        end
    end

    // Per-leg dead-time sequencer: 0/0 for dt_sh cycles after any target change, immediate off
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cur[k]    <= LEG_OFF;
                dt_cnt[k] <= '0;
            end
            hi <= '0;
            lo <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (trip || tgt[k] == LEG_OFF) begin
                    cur[k]    <= LEG_OFF;
                    dt_cnt[k] <= '0;
                    hi[k]     <= 1'b0;
                    lo[k]     <= 1'b0;
                end else if (tgt[k] != cur[k]) begin
                    cur[k]    <= tgt[k];
                    dt_cnt[k] <= dt_sh;
                    hi[k]     <= dt_sh == '0 && tgt[k] == LEG_HI;
                    lo[k]     <= dt_sh == '0 && tgt[k] == LEG_LO;
                end else begin
                    dt_cnt[k] <= dt_cnt[k] - DT_W'(dt_cnt[k] != '0);
                    hi[k]     <= dt_cnt[k][DT_W-1:1] == '0 && cur[k] == LEG_HI;
                    lo[k]     <= dt_cnt[k][DT_W-1:1] == '0 && cur[k] == LEG_LO;
                end
            end
        end
    end
endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// tb_hbridge_pwm_ctrl: directed scenario bench for hbridge_pwm_ctrl
module tb_hbridge_pwm_ctrl;
    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] duty = '0;
    logic [1:0] mode = '0;
    logic [3:0] dead_time = '0;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       h1, l1, h2, l2, ps, fl;
    int         tests = 0;
    int         fails = 0;

    always #5 sys_clk = ~sys_clk;

    hbridge_pwm_ctrl dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .duty(duty), .mode(mode),
        .dead_time(dead_time), .fault(fault), .fault_clr(fault_clr),
        .PWM_HIGH_1(h1), .PWM_LOW_1(l1), .PWM_HIGH_2(h2), .PWM_LOW_2(l2),
        .period_start(ps), .fault_latched(fl)
    );

    // move to the cnt==2 sample point of the current (if at cnt 0) or next period
    task automatic align();
        int n = 0;
        while (!ps && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        if (!ps) begin
            tests++;
            fails++;
            $display("FAIL align: period_start not seen within %0d cycles", n);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    // count gate-high cycles over one 256-cycle window starting at cnt==2
    task automatic measure(output int c1h, output int c1l, output int c2h, output int c2l, output int c00);
        c1h = 0; c1l = 0; c2h = 0; c2l = 0; c00 = 0;
        repeat (256) begin
            c1h += int'(h1);
            c1l += int'(l1);
            c2h += int'(h2);
            c2l += int'(l2);
            c00 += int'(!h1 && !l1);
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        int act = 0;
        rst_n = 1'b0; mode = 2'b01; duty = 8'd64; dead_time = 4'd0;
        repeat (3) @(negedge sys_clk);
        tests++;
        if ({h1, l1, h2, l2, ps, fl} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 000000", {h1, l1, h2, l2, ps, fl});
        end
        rst_n = 1'b1;
        do begin
            @(negedge sys_clk);
            n++;
            act += int'(h1 | l1 | h2 | l2);
        end while (!ps && n < 600);
        tests++;
        if (n !== 256) begin
            fails++;
            $display("FAIL reset_first_period: period_start after %0d cycles want 256", n);
        end
        tests++;
        if (act !== 0) begin
            fails++;
            $display("FAIL reset_off_period: %0d gate-active cycles want 0", act);
        end
    endtask

    task automatic test_soft_start();
        int exp_h [8] = '{0, 16, 32, 48, 64, 64, 64, 32};
        int c1h, c1l, c2h, c2l, c00;
        align();
        for (int p = 0; p < 8; p++) begin
            if (p == 6) duty = 8'd32;
            measure(c1h, c1l, c2h, c2l, c00);
            tests++;
            if (c1h !== exp_h[p]) begin
                fails++;
                $display("FAIL soft_start_p%0d: HIGH_1 on %0d want %0d", p, c1h, exp_h[p]);
            end
            tests++;
            if (c1l !== 256 - exp_h[p]) begin
                fails++;
                $display("FAIL soft_start_low_p%0d: LOW_1 on %0d want %0d", p, c1l, 256 - exp_h[p]);
            end
        end
    endtask

    task automatic test_buck_dt0();
        int c1h, c1l, c2h, c2l, c00;
        duty = 8'd64;
        repeat (3) measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if ({c1h, c1l, c2h, c2l} !== {32'd64, 32'd192, 32'd256, 32'd0}) begin
            fails++;
            $display("FAIL buck_dt0: H1=%0d L1=%0d H2=%0d L2=%0d want 64 192 256 0", c1h, c1l, c2h, c2l);
        end
    endtask

    task automatic test_dead_time();
        int c1h, c1l, c2h, c2l, c00;
        duty = 8'd128;
        dead_time = 4'd3;
        repeat (5) measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if ({c1h, c1l, c00} !== {32'd125, 32'd125, 32'd6}) begin
            fails++;
            $display("FAIL dead_time_leg1: H1=%0d L1=%0d off=%0d want 125 125 6", c1h, c1l, c00);
        end
        tests++;
        if ({c2h, c2l} !== {32'd256, 32'd0}) begin
            fails++;
            $display("FAIL dead_time_leg2: H2=%0d L2=%0d want 256 0", c2h, c2l);
        end
    endtask

    task automatic test_mode_change();
        logic [3:0] exp_v [5] = '{4'b0110, 4'b0010, 4'b0000, 4'b1000, 4'b1001};
        int bad = 0;
        int n = 0;
        measure_skip();
        mode = 2'b10;
        dead_time = 4'd2;
        while (!ps && n < 100) begin
            bad += int'({h1, l1, h2, l2} !== 4'b0110);
            @(negedge sys_clk);
            n++;
        end
        tests++;
        if (bad !== 0 || !ps) begin
            fails++;
            $display("FAIL mode_mid_period: %0d changed cycles, wrap seen=%0b want 0 and 1", bad, ps);
        end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({h1, l1, h2, l2} !== exp_v[c]) begin
                fails++;
                $display("FAIL mode_switch_cnt%0d: gates %b want %b", c, {h1, l1, h2, l2}, exp_v[c]);
            end
            @(negedge sys_clk);
        end
    endtask

    // from cnt 2 advance to cnt 200, where leg 1 sits low in BUCK
    task automatic measure_skip();
        repeat (198) @(negedge sys_clk);
    endtask

    task automatic test_fault();
        int c1h, c1l, c2h, c2l, c00;
        int act = 0;
        int n = 0;
        mode = 2'b11; duty = 8'd128; dead_time = 4'd0;
        align();
        repeat (48) @(negedge sys_clk);
        tests++;
        if ({h1, l1, h2, l2} !== 4'b1001) begin
            fails++;
            $display("FAIL fault_pre: gates %b want 1001", {h1, l1, h2, l2});
        end
        fault = 1'b1;
        @(negedge sys_clk);
        tests++;
        if ({h1, l1, h2, l2, fl} !== 5'b00001) begin
            fails++;
            $display("FAIL fault_trip: gates/latch %b want 00001", {h1, l1, h2, l2, fl});
        end
        fault_clr = 1'b1;
        @(negedge sys_clk);
        tests++;
        if (fl !== 1'b1) begin
            fails++;
            $display("FAIL fault_wins: latch %b want 1", fl);
        end
        fault = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests++;
        if ({h1, l1, h2, l2, fl} !== 5'b00001) begin
            fails++;
            $display("FAIL fault_hold: gates/latch %b want 00001", {h1, l1, h2, l2, fl});
        end
        fault_clr = 1'b1;
        @(negedge sys_clk);
        fault_clr = 1'b0;
        tests++;
        if (fl !== 1'b0) begin
            fails++;
            $display("FAIL fault_clear: latch %b want 0", fl);
        end
        while (!ps && n < 300) begin
            act += int'(h1 | l1 | h2 | l2);
            @(negedge sys_clk);
            n++;
        end
        tests++;
        if (act !== 0 || !ps) begin
            fails++;
            $display("FAIL fault_off_until_boundary: %0d active cycles, wrap seen=%0b want 0 and 1", act, ps);
        end
        align();
        measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if ({c1h, c1l, c2h, c2l} !== {32'd0, 32'd256, 32'd256, 32'd0}) begin
            fails++;
            $display("FAIL fault_restart_p0: H1=%0d L1=%0d H2=%0d L2=%0d want 0 256 256 0", c1h, c1l, c2h, c2l);
        end
        measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if ({c1h, c1l, c2h, c2l} !== {32'd16, 32'd240, 32'd240, 32'd16}) begin
            fails++;
            $display("FAIL fault_restart_p1: H1=%0d L1=%0d H2=%0d L2=%0d want 16 240 240 16", c1h, c1l, c2h, c2l);
        end
        fault_clr = 1'b1;
        @(negedge sys_clk);
        fault_clr = 1'b0;
        tests++;
        if (fl !== 1'b0) begin
            fails++;
            $display("FAIL fault_clr_idle: latch %b want 0", fl);
        end
    endtask

    task automatic test_reset_midop();
        int n = 0;
        repeat (9) @(negedge sys_clk);
        tests++;
        if ({h1, l2} !== 2'b11) begin
            fails++;
            $display("FAIL reset_mid_pre: H1/L2 %b want 11", {h1, l2});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({h1, l1, h2, l2, ps, fl} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got %b want 000000", {h1, l1, h2, l2, ps, fl});
        end
        mode = 2'b01; duty = 8'd255; dead_time = 4'd0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!ps && n < 600);
        tests++;
        if (n !== 256) begin
            fails++;
            $display("FAIL reset_mid_cnt: period_start after %0d cycles want 256", n);
        end
    endtask

    task automatic test_full_duty();
        int c1h, c1l, c2h, c2l, c00;
        align();
        repeat (15) measure(c1h, c1l, c2h, c2l, c00);
        measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if (c1h !== 240) begin
            fails++;
            $display("FAIL full_duty_p16: H1=%0d want 240", c1h);
        end
        measure(c1h, c1l, c2h, c2l, c00);
        tests++;
        if ({c1h, c1l} !== {32'd255, 32'd1}) begin
            fails++;
            $display("FAIL full_duty_sat: H1=%0d L1=%0d want 255 1", c1h, c1l);
        end
    endtask

    task automatic test_random();
        int viol = 0;
        logic pf = 1'b0;
        repeat (4000) begin
            @(negedge sys_clk);
            viol += int'((h1 && l1) || (h2 && l2));
            viol += int'(pf && ({h1, l1, h2, l2} !== 4'b0 || fl !== 1'b1));
            pf = fault;
            if ($urandom_range(0, 39) == 0) begin
                mode = 2'($urandom_range(0, 3));
                duty = 8'($urandom);
                dead_time = 4'($urandom);
            end
            fault = $urandom_range(0, 499) == 0;
            fault_clr = $urandom_range(0, 99) == 0;
        end
        fault = 1'b0;
        fault_clr = 1'b0;
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL random_shoot_through: %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_buck_dt0();
        test_dead_time();
        test_mode_change();
        test_fault();
        test_reset_midop();
        test_full_duty();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
